// File: rtl/trb_pkg.sv
// Shared definitions for the turbo-decoder packet order arbiter.
//   trb_state_e   : arbiter FSM encodings (IDLE between packets, XFER inside one)
//   TRB_DW        : decoder data beat width
//   TRB_NUM_TURBO : default decoder stream count
//   TRB_PKT_BEATS : beats in one decoded block (1024-bit block / 8-bit beats)
//   trb_next_idx  : round-robin successor of a stream index
package trb_pkg;

  localparam int TRB_DW        = 8;
  localparam int TRB_NUM_TURBO = 2;
  localparam int TRB_PKT_BEATS = 128;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } trb_state_e;

  function automatic int trb_next_idx(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/trb_skid_buf.sv
// Two-entry registered skid buffer.
//   clk_i       : clock
//   rst_n_i     : synchronous reset, active low
//   in_data_i   : upstream payload
//   in_valid_i  : upstream valid
//   in_ready_o  : upstream ready, straight from a flop (skid entry empty)
//   out_data_o  : registered payload, held while stalled
//   out_valid_o : registered valid
//   out_ready_i : downstream ready
// The output register is the head entry; the skid entry only fills when the
// head is stalled, so a beat accepted with ready high is never lost and
// in_ready_o never sees out_ready_i combinationally.
module trb_skid_buf #(
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic [W-1:0] out_q, out_d, skd_q, skd_d;
  logic         out_vld_q, out_vld_d, skd_vld_q, skd_vld_d;
  logic         rdy_q, rdy_d;
  logic         push, pop;

  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    skd_d     = skd_q;
    skd_vld_d = skd_vld_q;
    push      = in_valid_i & rdy_q;
    pop       = out_vld_q & out_ready_i;
    if (!out_vld_q || pop) begin
      // head free this cycle: refill from skid first to keep order
      if (skd_vld_q) begin
        out_vld_d = 1'b1;
        out_d     = skd_q;
        skd_vld_d = 1'b0;
      end else begin
        out_vld_d = push;
        if (push) out_d = in_data_i;
      end
    end else if (push) begin
      skd_vld_d = 1'b1;
      skd_d     = in_data_i;
    end
    rdy_d = ~skd_vld_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
      skd_q     <= '0;
      skd_vld_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      skd_q     <= skd_d;
      skd_vld_q <= skd_vld_d;
      rdy_q     <= rdy_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_data_o  = out_q;
  assign out_valid_o = out_vld_q;

endmodule

// File: rtl/trb_pkt_order_arb.sv
// Packet-atomic, in-order merge of NUM_TURBO decoder Avalon-ST streams.
// Streams are granted strictly round-robin, one whole packet at a time, so
// output packet order equals dispatch order. A skid stage registers the output.
//   clk_st / rst_n            : stream clock, synchronous active-low reset
//   st_data_in/valid/sop/eop  : decoder i at bit i (data at [i*DW +: DW])
//   st_ready_out              : one-hot ready, only the granted stream
//   st_ready_in               : downstream ready
//   st_data/valid/sop/eop_out : merged stream
//   grant_ptr                 : stream currently granted
//   proto_err                 : sticky; sop missing at packet start or sop inside a packet
// Optional (macro TRB_ARB_PKT_CNT_EN): pkt_cnt (downstream eop handshakes) and
// err_cnt (protocol violation events), both saturating.
// PW must satisfy 2**PW >= NUM_TURBO.
module trb_pkt_order_arb
  import trb_pkg::*;
#(
  parameter int NUM_TURBO = TRB_NUM_TURBO,
  parameter int DW        = TRB_DW,
  parameter int PW        = 4
) (
  input  logic                    clk_st,
  input  logic                    rst_n,
  input  logic [NUM_TURBO*DW-1:0] st_data_in,
  input  logic [NUM_TURBO-1:0]    st_valid_in,
  input  logic [NUM_TURBO-1:0]    st_sop_in,
  input  logic [NUM_TURBO-1:0]    st_eop_in,
  output logic [NUM_TURBO-1:0]    st_ready_out,
  input  logic                    st_ready_in,
  output logic [DW-1:0]           st_data_out,
  output logic                    st_valid_out,
  output logic                    st_sop_out,
  output logic                    st_eop_out,
  output logic [PW-1:0]           grant_ptr,
  output logic                    proto_err
`ifdef TRB_ARB_PKT_CNT_EN
  ,
  output logic [31:0]             pkt_cnt,
  output logic [15:0]             err_cnt
`endif
);

  trb_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, ptr_nxt;
  logic          err_q, err_evt;
  logic          skid_rdy, acc, fwd;
  logic          sel_vld, sel_sop, sel_eop;
  logic [DW-1:0] sel_data;

  // stream mux on the grant pointer
  always_comb begin
    sel_vld  = 1'b0;
    sel_sop  = 1'b0;
    sel_eop  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_TURBO; i++) begin
      if (ptr_q == PW'(i)) begin
        sel_vld  = st_valid_in[i];
        sel_sop  = st_sop_in[i];
        sel_eop  = st_eop_in[i];
        sel_data = st_data_in[i*DW +: DW];
      end
    end
  end

  for (genvar g = 0; g < NUM_TURBO; g++) begin : g_rdy
    assign st_ready_out[g] = (ptr_q == PW'(g)) & skid_rdy;
  end

  assign acc     = sel_vld & skid_rdy;
  assign ptr_nxt = PW'(trb_next_idx(int'(ptr_q), NUM_TURBO));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    fwd     = 1'b0;
    err_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (sel_sop) begin
            fwd = 1'b1;
            if (sel_eop) ptr_d   = ptr_nxt;
            else         state_d = XFER;
          end else begin
            // headless beat: swallow it so the stream can resync on a real sop
            err_evt = 1'b1;
          end
        end
      end
      XFER: begin
        if (acc) begin
          fwd = 1'b1;
          if (sel_sop) err_evt = 1'b1;  // stray sop is passed through, packet continues
          if (sel_eop) begin
            ptr_d   = ptr_nxt;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_st) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_q | err_evt;
    end
  end

  trb_skid_buf #(.W(DW + 2)) u_skid (
    .clk_i       (clk_st),
    .rst_n_i     (rst_n),
    .in_data_i   ({sel_sop, sel_eop, sel_data}),
    .in_valid_i  (fwd),
    .in_ready_o  (skid_rdy),
    .out_data_o  ({st_sop_out, st_eop_out, st_data_out}),
    .out_valid_o (st_valid_out),
    .out_ready_i (st_ready_in)
  );

  assign grant_ptr = ptr_q;
  assign proto_err = err_q;

`ifdef TRB_ARB_PKT_CNT_EN
  logic [31:0] pkt_cnt_q;
  logic [15:0] err_cnt_q;
  logic        eop_hs;

  assign eop_hs = st_valid_out & st_ready_in & st_eop_out;

  always_ff @(posedge clk_st) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (eop_hs && pkt_cnt_q != '1)  pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (err_evt && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_trb_pkt_order_arb.sv
// Directed bench for trb_pkt_order_arb, built with three decoder streams so
// the round-robin wrap is exercised. Source queues feed each stream; output
// beats are captured as {sop,eop,data} and compared against packets the bench
// builds from constants.
module tb_trb_pkt_order_arb;
  import trb_pkg::*;

  localparam int NT = 3;
  localparam int DW = TRB_DW;
  localparam int PW = 4;
  localparam int BW = DW + 2;

  logic clk_st = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_st = ~clk_st;

  logic [NT*DW-1:0] st_data_in  = '0;
  logic [NT-1:0]    st_valid_in = '0;
  logic [NT-1:0]    st_sop_in   = '0;
  logic [NT-1:0]    st_eop_in   = '0;
  logic [NT-1:0]    st_ready_out;
  logic             st_ready_in = 1'b1;
  logic [DW-1:0]    st_data_out;
  logic             st_valid_out, st_sop_out, st_eop_out;
  logic [PW-1:0]    grant_ptr;
  logic             proto_err;
`ifdef TRB_ARB_PKT_CNT_EN
  logic [31:0]      pkt_cnt;
  logic [15:0]      err_cnt;
`endif

  trb_pkt_order_arb #(.NUM_TURBO(NT), .DW(DW), .PW(PW)) u_dut (
    .clk_st       (clk_st),
    .rst_n        (rst_n),
    .st_data_in   (st_data_in),
    .st_valid_in  (st_valid_in),
    .st_sop_in    (st_sop_in),
    .st_eop_in    (st_eop_in),
    .st_ready_out (st_ready_out),
    .st_ready_in  (st_ready_in),
    .st_data_out  (st_data_out),
    .st_valid_out (st_valid_out),
    .st_sop_out   (st_sop_out),
    .st_eop_out   (st_eop_out),
    .grant_ptr    (grant_ptr),
    .proto_err    (proto_err)
`ifdef TRB_ARB_PKT_CNT_EN
    ,
    .pkt_cnt      (pkt_cnt),
    .err_cnt      (err_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int rdy_mode = 0;  // 0: ready high, 1: ready low, 2: random

  logic [BW-1:0] srcq [NT][$];
  logic [BW-1:0] obs[$];
  logic [BW-1:0] exp_q[$];
  int            obs_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // One clock: note handshakes due at the coming posedge, then at the
  // following negedge retire accepted source beats and drive new inputs.
  task automatic step();
    logic [NT-1:0] fire;
    logic          stall;
    logic [BW-1:0] held;
    fire  = st_valid_in & st_ready_out & {NT{rst_n}};
    held  = {st_sop_out, st_eop_out, st_data_out};
    stall = st_valid_out & ~st_ready_in & rst_n;
    if (st_valid_out && st_ready_in && rst_n) begin
      obs.push_back(held);
      obs_cyc.push_back(cyc);
    end
    @(negedge clk_st);
    cyc++;
    if (stall) begin
      chk("hold valid", 32'(st_valid_out), 32'd1);
      chk("hold beat", 32'({st_sop_out, st_eop_out, st_data_out}), 32'(held));
    end
    for (int i = 0; i < NT; i++)
      if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    for (int i = 0; i < NT; i++) begin
      if (srcq[i].size() > 0) begin
        {st_sop_in[i], st_eop_in[i], st_data_in[i*DW +: DW]} = srcq[i][0];
        st_valid_in[i] = 1'b1;
      end else begin
        st_sop_in[i] = 1'b0;
        st_eop_in[i] = 1'b0;
        st_data_in[i*DW +: DW] = '0;
        st_valid_in[i] = 1'b0;
      end
    end
    case (rdy_mode)
      0:       st_ready_in = 1'b1;
      1:       st_ready_in = 1'b0;
      default: st_ready_in = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic add_pkt(input int s, input int n, input logic [DW-1:0] base);
    for (int b = 0; b < n; b++)
      srcq[s].push_back({(b == 0), (b == n - 1), DW'(base + DW'(b))});
  endtask

  task automatic exp_pkt(input int n, input logic [DW-1:0] base);
    for (int b = 0; b < n; b++)
      exp_q.push_back({(b == 0), (b == n - 1), DW'(base + DW'(b))});
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int k = 0;
    while (obs.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(obs.size()), 32'(n));
  endtask

  task automatic cmp_obs(input string tag);
    chk({tag, " beats"}, 32'(obs.size()), 32'(exp_q.size()));
    for (int k = 0; k < obs.size() && k < exp_q.size(); k++)
      chk($sformatf("%s[%0d]", tag, k), 32'(obs[k]), 32'(exp_q[k]));
  endtask

  task automatic clr();
    for (int i = 0; i < NT; i++) srcq[i].delete();
    obs.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    rdy_mode = 0;
    repeat (3) step();
    clr();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: cycle %0d, limit reached", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // T1: reset in the middle of a stalled stream-1 packet
    add_pkt(0, 1, 8'hA1);
    add_pkt(1, 10, 8'hB0);
    repeat (5) step();
    rdy_mode = 1;
    repeat (3) step();
    chk("T1 ptr before reset", 32'(grant_ptr), 32'd1);
    chk("T1 valid before reset", 32'(st_valid_out), 32'd1);
    rst_n = 1'b0;
    repeat (3) step();
    chk("T1 rst valid", 32'(st_valid_out), 32'd0);
    chk("T1 rst sop", 32'(st_sop_out), 32'd0);
    chk("T1 rst eop", 32'(st_eop_out), 32'd0);
    chk("T1 rst data", 32'(st_data_out), 32'd0);
    chk("T1 rst ready", 32'(st_ready_out), 32'd0);
    chk("T1 rst ptr", 32'(grant_ptr), 32'd0);
    chk("T1 rst proto_err", 32'(proto_err), 32'd0);
    clr();
    rst_n    = 1'b1;
    rdy_mode = 0;
    step();
    add_pkt(1, 2, 8'hC0);
    repeat (4) step();
    chk("T1 stream1 waits", 32'(obs.size()), 32'd0);
    chk("T1 ptr after reset", 32'(grant_ptr), 32'd0);
    add_pkt(0, 2, 8'hD0);
    exp_pkt(2, 8'hD0);
    exp_pkt(2, 8'hC0);
    run_until(4, 50, "T1 done");
    cmp_obs("T1");

    // T2: stream 1 valid first, stream 0 must still go first; no bubbles
    do_reset();
    add_pkt(1, TRB_PKT_BEATS, 8'h80);
    repeat (3) step();
    add_pkt(0, TRB_PKT_BEATS, 8'h00);
    exp_pkt(TRB_PKT_BEATS, 8'h00);
    exp_pkt(TRB_PKT_BEATS, 8'h80);
    run_until(2 * TRB_PKT_BEATS, 800, "T2 done");
    cmp_obs("T2");
    if (obs_cyc.size() == 2 * TRB_PKT_BEATS)
      chk("T2 back-to-back span", 32'(obs_cyc[2*TRB_PKT_BEATS-1] - obs_cyc[0]),
          32'(2 * TRB_PKT_BEATS - 1));

    // T3: random downstream backpressure
    do_reset();
    rdy_mode = 2;
    add_pkt(0, TRB_PKT_BEATS, 8'h00);
    exp_pkt(TRB_PKT_BEATS, 8'h00);
    run_until(TRB_PKT_BEATS, 3000, "T3 done");
    cmp_obs("T3");
    rdy_mode = 0;

    // T4: single-beat packets on every stream, pointer wraps home
    do_reset();
    add_pkt(0, 1, 8'hE0);
    add_pkt(1, 1, 8'hE1);
    add_pkt(2, 1, 8'hE2);
    exp_pkt(1, 8'hE0);
    exp_pkt(1, 8'hE1);
    exp_pkt(1, 8'hE2);
    run_until(3, 50, "T4 done");
    cmp_obs("T4");
    chk("T4 ptr", 32'(grant_ptr), 32'd0);

    // T5: headless beat in IDLE, then a stray sop inside a packet
    do_reset();
    srcq[0].push_back({1'b0, 1'b0, 8'h55});
    repeat (5) step();
    chk("T5 dropped", 32'(obs.size()), 32'd0);
    chk("T5 proto_err", 32'(proto_err), 32'd1);
    chk("T5 ptr held", 32'(grant_ptr), 32'd0);
    chk("T5 src drained", 32'(srcq[0].size()), 32'd0);
`ifdef TRB_ARB_PKT_CNT_EN
    chk("T5 err_cnt", 32'(err_cnt), 32'd1);
`endif
    srcq[0].push_back({1'b1, 1'b0, 8'h60});
    srcq[0].push_back({1'b1, 1'b0, 8'h61});
    srcq[0].push_back({1'b0, 1'b1, 8'h62});
    exp_q.push_back({1'b1, 1'b0, 8'h60});
    exp_q.push_back({1'b1, 1'b0, 8'h61});
    exp_q.push_back({1'b0, 1'b1, 8'h62});
    run_until(3, 50, "T5 done");
    cmp_obs("T5");
    chk("T5 proto_err sticky", 32'(proto_err), 32'd1);
    chk("T5 ptr advanced", 32'(grant_ptr), 32'd1);
`ifdef TRB_ARB_PKT_CNT_EN
    chk("T5 err_cnt 2", 32'(err_cnt), 32'd2);
`endif

    // T6: seven 2-beat packets across three streams
    do_reset();
    for (int p = 0; p < 7; p++) begin
      add_pkt(p % 3, 2, 8'((p % 3) * 16 + (p / 3) * 2));
      exp_pkt(2, 8'((p % 3) * 16 + (p / 3) * 2));
    end
    run_until(14, 200, "T6 done");
    cmp_obs("T6");
    chk("T6 ptr", 32'(grant_ptr), 32'd1);
`ifdef TRB_ARB_PKT_CNT_EN
    chk("T6 pkt_cnt", pkt_cnt, 32'd7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
